// File: rtl/qspi_ram_arbiter.sv
// Two-requester byte arbiter in front of a QSPI PSRAM: QPI init, then read/write transactions.
// Define QSPI_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module qspi_ram_arbiter #(
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  wr,
  input  logic [51:0] addr,
  input  logic [15:0] wdata,
  output logic [7:0]  rdata,
  output logic [1:0]  ack,
  output logic        busy,
  output logic        ram_clk,
  output logic        ram_csn,
  output logic [1:0]  ram_bank,
  output logic [3:0]  ram_io_o,
  output logic [3:0]  ram_io_oe,
  input  logic [3:0]  ram_io_i
);
  typedef enum logic [2:0] {INIT_QX, INIT_SPI, IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;

  localparam int CW = $clog2((DUMMY_CYCLES > 8 ? DUMMY_CYCLES : 8) + 1);
  localparam logic [7:0] QPI_ENTER = 8'h35;

  state_t          state, st_n;
  logic            ph;
  logic [CW-1:0]   cnt, idx_n, len;
  logic            fin, gnt, g, l_wr;
  logic [23:0]     l_addr;
  logic [7:0]      l_wd, cmd;
  logic [3:0]      rx_hi, nib_n, oe_n;

`ifdef QSPI_ARB_RR_EN
  logic last;
  assign g = (&req) ? ~last : ~req[0];
`else
  assign g = ~req[0];
`endif

  assign cmd = l_wr ? 8'h38 : 8'hEB;
  assign fin = (cnt == len);

  always_comb begin
    len = '0;
    case (state)
      INIT_QX, CMD, DATA: len = CW'(2);
      INIT_SPI:           len = CW'(8);
      ADDR:               len = CW'(6);
      DUMMY:              len = CW'(DUMMY_CYCLES);
      default:            len = '0;
    endcase
  end

  // cnt = SCLKs already sent in this state; on exhaustion, chain to the next phase
  always_comb begin
    st_n  = state;
    idx_n = cnt;
    if (fin) begin
      idx_n = '0;
      case (state)
        CMD:     st_n = ADDR;
        ADDR:    st_n = (l_wr || DUMMY_CYCLES == 0) ? DATA : DUMMY;
        DUMMY:   st_n = DATA;
        default: st_n = state;
      endcase
    end
  end

  always_comb begin
    nib_n = '0;
    oe_n  = '0;
    case (st_n)
      INIT_QX:  begin nib_n = idx_n[0] ? 4'h5 : 4'hF; oe_n = 4'hF; end
      INIT_SPI: begin nib_n = {3'b000, QPI_ENTER[3'd7 - idx_n[2:0]]}; oe_n = 4'b0001; end
      CMD:      begin nib_n = idx_n[0] ? cmd[3:0] : cmd[7:4]; oe_n = 4'hF; end
      ADDR:     begin nib_n = 4'((l_addr << {idx_n[2:0], 2'b00}) >> 20); oe_n = 4'hF; end
      DATA:     if (l_wr) begin nib_n = idx_n[0] ? l_wd[3:0] : l_wd[7:4]; oe_n = 4'hF; end
      default:  ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= INIT_QX;
      ph        <= 1'b1;
      cnt       <= '0;
      ram_csn   <= 1'b1;
      ram_clk   <= 1'b0;
      ram_io_o  <= '0;
      ram_io_oe <= '0;
      ack       <= '0;
      busy      <= 1'b1;
      rdata     <= '0;
      ram_bank  <= '0;
      gnt       <= 1'b0;
      l_wr      <= 1'b0;
      l_addr    <= '0;
      l_wd      <= '0;
      rx_hi     <= '0;
`ifdef QSPI_ARB_RR_EN
      last      <= 1'b1;
`endif
    end else begin
      ack <= '0;
      case (state)
        IDLE: if (|req) begin
          gnt      <= g;
          l_wr     <= wr[g];
          l_addr   <= g ? addr[49:26] : addr[23:0];
          ram_bank <= g ? addr[51:50] : addr[25:24];
          l_wd     <= g ? wdata[15:8] : wdata[7:0];
          state    <= CMD;
          cnt      <= '0;
          ph       <= 1'b1;
          ram_csn  <= 1'b0;
          busy     <= 1'b1;
`ifdef QSPI_ARB_RR_EN
          last     <= g;
`endif
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: if (!ph) begin
          ram_clk <= 1'b1;
          ph      <= 1'b1;
        end else begin
          // end of phase B (or a csn-low lead/gap cycle when ram_clk is still low)
          if (ram_clk && state == DATA && !l_wr) begin
            if (cnt == CW'(1)) rx_hi <= ram_io_i;
            else               rdata <= {rx_hi, ram_io_i};
          end
          ram_clk <= 1'b0;
          if (fin && (state == INIT_QX || state == INIT_SPI || state == DATA)) begin
            ram_csn   <= 1'b1;
            ram_io_o  <= '0;
            ram_io_oe <= '0;
            cnt       <= '0;
            case (state)
              INIT_QX:  state <= INIT_SPI;
              INIT_SPI: begin state <= IDLE; busy <= 1'b0; end
              default:  begin state <= DONE; ack[gnt] <= 1'b1; end
            endcase
          end else begin
            state     <= st_n;
            cnt       <= idx_n + 1'b1;
            ph        <= 1'b0;
            ram_csn   <= 1'b0;
            ram_io_o  <= nib_n;
            ram_io_oe <= oe_n;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qspi_ram_arbiter.sv
// Random + directed bench for qspi_ram_arbiter: bus-level RAM slave and a transaction-level reference model.
module tb_qspi_ram_arbiter;
  localparam int D = 6;
`ifdef QSPI_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [7:0] QPI_ON = 8'h35;

  logic        clock = 1'b0, reset = 1'b0;
  logic [1:0]  req = '0, wr = '0;
  logic [51:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [7:0]  rdata;
  logic [1:0]  ack, ram_bank;
  logic        busy, ram_clk, ram_csn;
  logic [3:0]  ram_io_o, ram_io_oe;
  logic [3:0]  ram_io_i = '0;

  int n_chk = 0, n_pass = 0;

  always #5 clock = ~clock;

  qspi_ram_arbiter #(.DUMMY_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .ram_clk(ram_clk), .ram_csn(ram_csn),
    .ram_bank(ram_bank), .ram_io_o(ram_io_o), .ram_io_oe(ram_io_oe), .ram_io_i(ram_io_i)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // RAM contents not yet written by anyone
  function automatic logic [7:0] dflt(input logic [25:0] k);
    return k[7:0] ^ k[15:8] ^ k[23:16] ^ 8'h2C;
  endfunction

  // ---------------- bus monitor + RAM slave ----------------
  int          cyc = 0, last_idle = 0, gap_cnt = 0;
  bit          seen_low = 1'b0;
  logic [7:0]  frame_q[$];
  logic [7:0]  sl_q[$];
  logic [7:0]  ram_mem [logic [25:0]];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      gap_cnt  = 0;
      seen_low = 1'b0;
      sl_q.delete();
    end else begin
      if (!busy) last_idle = cyc;
      if (!ram_csn) seen_low = 1'b1;
      else if (busy && seen_low) gap_cnt++;
      if (ram_csn) sl_q.delete();
      else if (ram_clk) begin
        int k;
        logic [7:0]  c, b;
        logic [25:0] key;
        frame_q.push_back({ram_io_oe, ram_io_o});
        sl_q.push_back({ram_io_oe, ram_io_o});
        k = sl_q.size() - 1;
        if (k >= 8) begin
          c   = {sl_q[0][3:0], sl_q[1][3:0]};
          key = {ram_bank, sl_q[2][3:0], sl_q[3][3:0], sl_q[4][3:0],
                 sl_q[5][3:0], sl_q[6][3:0], sl_q[7][3:0]};
          b   = ram_mem.exists(key) ? ram_mem[key] : dflt(key);
          if (c == 8'hEB && k == 8 + D)     ram_io_i = b[7:4];
          if (c == 8'hEB && k == 9 + D)     ram_io_i = b[3:0];
          if (c == 8'h38 && k == 9)         ram_mem[key] = {sl_q[8][3:0], sl_q[9][3:0]};
        end
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [7:0] exp_mem [logic [25:0]];
  logic [7:0] exp_rdata = '0;
  int         lastg = 1;

  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin tick(); n++; end
    if (busy !== 1'b0) chk("idle_timeout", busy, 0);
  endtask

  task automatic check_init();
    int fb;
    logic [7:0] e;
    fb = frame_q.size();
    reset = 1'b1;
    lastg = 1;
    tick();
    chk("init_start_csn", ram_csn, 0);
    chk("init_first_nib", {ram_io_oe, ram_io_o}, 8'hFF);
    wait_idle();
    chk("init_len", frame_q.size() - fb, 10);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      e = 8'hFF;
      else if (i == 1) e = 8'hF5;
      else             e = {4'b0001, 3'b000, QPI_ON[7 - (i - 2)]};
      if (fb + i < frame_q.size()) chk("init_nib", frame_q[fb + i], e);
    end
    chk("init_gap", gap_cnt, 1);
    chk("idle_lines", {ram_csn, ram_clk, ram_io_oe}, {1'b1, 1'b0, 4'h0});
  endtask

  task automatic serve(input logic [1:0] rq, input logic [1:0] w_wr, input logic [51:0] w_ad,
                       input logic [15:0] w_wd, input bit pulse_other, output int win);
    int fb, t0, lat, oth;
    bit w;
    logic [25:0] k;
    logic [7:0] d, cmd, got;
    logic [7:0] exp_q[$];
    wait_idle();
    fb = frame_q.size();
    req = rq; wr = w_wr; addr = w_ad; wdata = w_wd;
    win   = (rq == 2'b11) ? (RR ? 1 - lastg : 0) : (rq[0] ? 0 : 1);
    lastg = win;
    oth   = 1 - win;
    w   = w_wr[win];
    k   = w_ad[26*win +: 26];
    d   = w_wd[8*win +: 8];
    cmd = w ? 8'h38 : 8'hEB;
    exp_q.push_back({4'hF, cmd[7:4]});
    exp_q.push_back({4'hF, cmd[3:0]});
    for (int i = 0; i < 6; i++) exp_q.push_back({4'hF, 4'(k[23:0] >> (20 - 4*i))});
    if (w) begin
      exp_q.push_back({4'hF, d[7:4]});
      exp_q.push_back({4'hF, d[3:0]});
      exp_mem[k] = d;
    end else begin
      for (int i = 0; i < D + 2; i++) exp_q.push_back(8'h00);
      exp_rdata = exp_mem.exists(k) ? exp_mem[k] : dflt(k);
    end
    t0 = 0;
    do begin
      tick(); t0++;
      if (ack == 2'b00) begin
        wr = 2'($urandom); addr = 52'({$urandom, $urandom}); wdata = 16'($urandom);
        if (pulse_other && t0 == 3) req[oth] = 1'b1;
        if (pulse_other && t0 == 8) req[oth] = 1'b0;
      end
    end while (ack == 2'b00 && t0 < 80);
    if (ack == 2'b00) begin
      chk("ack_timeout", 0, 1);
      return;
    end
    lat = cyc - last_idle;
    chk("latency", lat, w ? 22 : 2 * (10 + D) + 2);
    chk("ack", ack, 2'b01 << win);
    chk("bank", ram_bank, k[25:24]);
    chk("rdata", rdata, exp_rdata);
    chk("frame_len", frame_q.size() - fb, exp_q.size());
    for (int i = 0; i < exp_q.size() && fb + i < frame_q.size(); i++) begin
      got = frame_q[fb + i];
      if (got[7:4] == 4'h0) got = 8'h00;
      chk("nib", got, exp_q[i]);
    end
    tick();
    chk("ack_pulse", ack, 0);
    chk("rdata_hold", rdata, exp_rdata);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w1, w2, nb, n;
    logic [1:0]  rq;
    logic [51:0] a;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_csn", ram_csn, 1);
    chk("rst_clk", ram_clk, 0);
    chk("rst_oe", ram_io_oe, 0);
    chk("rst_io", ram_io_o, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_bank", ram_bank, 0);
    check_init();

    // write 0xA5 to bank 1, 0x123456 from requester 0
    serve(2'b01, 2'b01, {26'h0, 26'h1123456}, {8'h00, 8'hA5}, 1'b0, w1);
    req = '0;
    // read bank 0, 0x000010 from requester 1 (RAM holds 0x3C there)
    serve(2'b10, 2'b00, {26'h0000010, 26'h0}, 16'h0, 1'b0, w1);
    req = '0;
    chk("rdata_3c", rdata, 8'h3C);

    // both requesting, held across two transactions
    serve(2'b11, 2'b11, {26'h2000100, 26'h3000200}, 16'h5AC3, 1'b0, w1);
    serve(2'b11, 2'b00, {26'h2000100, 26'h3000200}, 16'h0, 1'b0, w2);
    req = '0;
    chk("held_first", w1, 0);
    chk("held_second", w2, RR ? 1 : 0);

    // a request raised and dropped mid-transaction must leave nothing behind
    serve(2'b01, 2'b00, {26'h0, 26'h0abcdef}, 16'h0, 1'b1, w1);
    req = '0;
    nb = 0;
    repeat (6) begin tick(); nb += int'(busy); end
    chk("no_spurious", nb, 0);

    // randomized traffic over a small address pool so reads hit earlier writes
    for (int it = 0; it < 16; it++) begin
      rq = 2'($urandom_range(1, 3));
      a  = 52'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) begin
        a[25:0]  = {2'($urandom), 21'h0, 3'($urandom_range(0, 7))};
        a[51:26] = {2'($urandom), 21'h0, 3'($urandom_range(0, 7))};
      end
      serve(rq, 2'($urandom), a, 16'($urandom), 1'b0, w1);
      req = '0;
    end

    // reset during the address phase of a read
    wait_idle();
    n = frame_q.size();
    req = 2'b10; wr = 2'b00; addr = {26'h1000040, 26'h0};
    w1 = 0;
    while (frame_q.size() - n < 4 && w1 < 100) begin tick(); w1++; end
    chk("addr_reached", frame_q.size() - n >= 4, 1);
    reset = 1'b0;
    req = '0;
    exp_rdata = '0;
    #1;
    chk("abort_csn", ram_csn, 1);
    chk("abort_oe", ram_io_oe, 0);
    chk("abort_busy", busy, 1);
    nb = 0;
    repeat (3) begin tick(); nb += int'(|ack); end
    chk("abort_no_ack", nb, 0);
    check_init();
    serve(2'b10, 2'b00, {26'h1000040, 26'h0}, 16'h0, 1'b0, w1);
    req = '0;
    serve(2'b11, 2'b01, {26'h0000123, 26'h2000777}, 16'h1177, 1'b0, w1);
    req = '0;
    chk("post_reset_win", w1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/qspi_ram_arbiter.md
QSPI_RAM_ARBITER -- requirements
Module: qspi_ram_arbiter

Interface
REQ-001 The module SHALL have parameter DUMMY_CYCLES, default 6: SCLK wait cycles between the read address and the read data.
REQ-002 The module SHALL have port clock  in  1  system clock; all logic on the rising edge.
REQ-003 The module SHALL have port reset  in  1  asynchronous, active-low reset (low = in reset).
REQ-004 The module SHALL have port req  in  2  per-requester request; bit n belongs to requester n.
REQ-005 The module SHALL have port wr  in  2  per-requester direction: 1 = write byte, 0 = read byte.
REQ-006 The module SHALL have port addr  in  52  two 26-bit addresses; [25:24] = bank, [23:0] = chip address; requester n uses addr[26n+25:26n].
REQ-007 The module SHALL have port wdata  in  16  write bytes; requester n uses wdata[8n+7:8n].
REQ-008 The module SHALL have port rdata  out  8  last read byte, shared by both requesters.
REQ-009 The module SHALL have port ack  out  2  one-cycle completion pulse per requester.
REQ-010 The module SHALL have port busy  out  1  high in every state other than IDLE.
REQ-011 The module SHALL have port ram_clk  out  1  QSPI SCLK.
REQ-012 The module SHALL have port ram_csn  out  1  QSPI chip select, active-low.
REQ-013 The module SHALL have port ram_bank  out  2  bank select, driven from the latched addr[25:24].
REQ-014 The module SHALL have ports ram_io_o  out  4, ram_io_oe  out  4 and ram_io_i  in  4  QSPI data out, output enable and data in.

Function
REQ-015 One SCLK period SHALL last 2 clock cycles. In phase A, ram_clk=0 and ram_io_o/ram_io_oe are updated. In phase B, ram_clk=1. Input nibbles SHALL be registered on the edge that ends phase B.
REQ-016 The states SHALL be INIT_QX, INIT_SPI, IDLE, CMD, ADDR, DUMMY, DATA and DONE.
REQ-017 INIT_QX SHALL send 0xF5 (QPI exit) as 2 QPI nibbles with csn low, then raise csn for 1 cycle.
REQ-018 INIT_SPI SHALL send 0x35 (enter QPI) MSB first on io0 only (oe=4'b0001) over 8 SCLKs, then raise csn for 1 cycle and go to IDLE.
REQ-019 In IDLE, csn=1, ram_clk=0 and oe=0. When any req bit is high, the arbiter SHALL grant one requester and latch its wr, addr and wdata in the same edge. It SHALL then enter CMD with csn low on the next cycle.
REQ-020 CMD SHALL send 2 nibbles: 0xEB for a read, 0x38 for a write. ADDR SHALL then send 6 nibbles, MSB first, of the latched addr[23:0].
REQ-021 On a read, DUMMY SHALL run DUMMY_CYCLES SCLKs with oe=0. DATA SHALL then receive 2 nibbles, high nibble first, into rdata.
REQ-022 On a write, DATA SHALL send the latched byte as 2 nibbles, high nibble first, with oe=4'b1111. There SHALL be no DUMMY state on a write.
REQ-023 In DONE (1 cycle), csn=1, ram_clk=0, oe=0 and ack[granted]=1. The next state SHALL be IDLE.
REQ-024 Transaction length from grant to ack SHALL be: write = 1 + 2*10 + 1 = 22 cycles; read = 1 + 2*(10+DUMMY_CYCLES) + 1 cycles, which is 34 at the default.
REQ-025 rdata SHALL be valid in the ack cycle and held until the next read completes. A write SHALL leave rdata unchanged.
REQ-026 req, wr, addr and wdata SHALL be ignored after grant. A req dropped before grant SHALL produce no transaction. A req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-027 When both req bits are high in the same IDLE cycle, the arbiter SHALL grant requester 0 (default behaviour, see REQ-032).
REQ-028 Requests arriving during a transaction SHALL wait; there SHALL be no preemption.

Reset
REQ-029 While reset=0, asynchronously: ram_csn=1, ram_clk=0, ram_io_oe=0, ram_io_o=0, ack=0, busy=1, rdata=0, ram_bank=0, and state=INIT_QX.
REQ-030 A reset asserted mid-transaction SHALL abort that transaction with no ack. After release, the full INIT_QX then INIT_SPI sequence SHALL run again.
REQ-031 INIT_QX SHALL start on the first edge after reset is released.

Configuration
REQ-032 The macro QSPI_ARB_RR_EN SHALL select the arbitration policy.
  - Defined: round-robin. On a simultaneous request, the requester not granted last SHALL win. The last-granted register SHALL reset to 1, so requester 0 wins first.
  - Undefined: fixed priority, requester 0 always wins.

Verification
REQ-033 Release reset -> io0 shifts 0x35 over 8 SCLKs after the 0xF5 nibbles, csn pulses high between them, busy falls on entry to IDLE.
REQ-034 Requester 0 writes 0xA5 to addr 0x1_123456 -> nibbles 3,8,1,2,3,4,5,6,A,5 on ram_io_o, ram_bank=1, ack[0] exactly 22 cycles after grant.
REQ-035 Requester 1 reads from addr 0x0_000010 with the model returning 0x3C -> nibbles E,B,0,0,0,0,1,0, then 6 SCLKs with oe=0, rdata=0x3C with ack[1] 34 cycles after grant.
REQ-036 req=2'b11 held for 2 transactions -> without the macro, requester 0 is granted twice and requester 1 never; with QSPI_ARB_RR_EN, grants go 0 then 1.
REQ-037 Reset pulsed during ADDR of a read -> csn=1 and oe=0 immediately, no ack, INIT sequence repeats, the next request completes normally.
